hms_bcd_counter: RTL and testbench

- Downstream consumer of the 1 Hz square wave generated from clk_50MHz; converts it into a 24-hour HH:MM:SS time-of-day held as six BCD digits.
- Samples the 1 Hz wave in the clk_50MHz domain, detects its rising edge, and advances the time by one second per edge.
- Supports run/pause and a validated parallel load (time set). Feeds the display/segment-drive stage.

---
 rtl/hms_pkg.sv | 34 +++
 rtl/bcd_digit_counter.sv | 53 +++++
 rtl/hms_bcd_counter.sv | 140 ++++++++++++++
 tb/tb_hms_bcd_counter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hms_pkg.sv
// Shared types and helpers for the HH:MM:SS BCD time-of-day counter.
// Provides the BCD digit type, the packed six-digit time struct
// {h1,h0,m1,m0,s1,s0} (same bit layout as the 24-bit time buses), the
// per-digit limits and a validity check for externally loaded times.
package hms_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef struct packed {
    bcd_digit_t h1;
    bcd_digit_t h0;
    bcd_digit_t m1;
    bcd_digit_t m0;
    bcd_digit_t s1;
    bcd_digit_t s0;
  } hms_t;

  localparam bcd_digit_t  SEC_TENS_MAX = 4'd5;
  localparam bcd_digit_t  MIN_TENS_MAX = 4'd5;
  localparam bcd_digit_t  DIGIT_MAX    = 4'd9;
  localparam int unsigned HOUR_MAX     = 23;

  // True when every digit is a legal BCD digit, tens of seconds/minutes are
  // at most 5 and the hour is at most 23.
  function automatic logic hms_valid(input hms_t t);
    logic ok;
    ok = (t.h1 <= DIGIT_MAX) && (t.h0 <= DIGIT_MAX) &&
         (t.m1 <= MIN_TENS_MAX) && (t.m0 <= DIGIT_MAX) &&
         (t.s1 <= SEC_TENS_MAX) && (t.s0 <= DIGIT_MAX);
    ok = ok && ((32'(t.h1) * 32'd10 + 32'(t.h0)) <= HOUR_MAX);
    return ok;
  endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// Single BCD digit counter with wrap at MAX.
//   clk, rst_n : clock, asynchronous active-low reset (loads RST_VAL)
//   inc        : advance by one; wraps MAX -> 0 and raises carry
//   clr        : synchronous clear to 0
//   ld, ld_val : synchronous parallel load (highest priority)
//   q          : registered digit value
//   carry      : combinational, high when inc wraps the digit
// A digit above MAX (unreachable in normal use) is treated as a wrap, so the
// next increment forces it to 0 and carries onward.
module bcd_digit_counter
  import hms_pkg::*;
#(
  parameter bcd_digit_t MAX     = DIGIT_MAX,
  parameter bcd_digit_t RST_VAL = '0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       clr,
  input  logic       ld,
  input  bcd_digit_t ld_val,
  output bcd_digit_t q,
  output logic       carry
);

  bcd_digit_t q_q;
  bcd_digit_t q_d;
  logic       at_max;

  always_comb begin
    at_max = (q_q >= MAX);
    carry  = inc && at_max;
    q_d    = q_q;
    if (ld) begin
      q_d = ld_val;
    end else if (clr) begin
      q_d = '0;
    end else if (inc) begin
      q_d = at_max ? '0 : q_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= RST_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/hms_bcd_counter.sv
// 24-hour HH:MM:SS BCD time-of-day counter driven by a 1 Hz square wave.
//   clk_50MHz : system clock
//   reset_n   : asynchronous active-low reset (time = RESET_TIME)
//   clk_1Hz   : asynchronous 1 Hz wave; each synchronised rising edge is a tick
//   run       : 1 = apply ticks, 0 = discard ticks (time held)
//   load      : single-cycle strobe to load load_time (validated)
//   load_time : BCD {H1,H0,M1,M0,S1,S0}
//   time_bcd  : current time, same packing as load_time
//   sec_pulse : 1-cycle pulse on each applied second increment
//   day_wrap  : 1-cycle pulse on 23:59:59 -> 00:00:00
//   load_err  : 1-cycle pulse when a load is rejected
module hms_bcd_counter
  import hms_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [23:0] RESET_TIME  = 24'h00_00_00
) (
  input  logic        clk_50MHz,
  input  logic        reset_n,
  input  logic        clk_1Hz,
  input  logic        run,
  input  logic        load,
  input  logic [23:0] load_time,
  output logic [23:0] time_bcd,
  output logic        sec_pulse,
  output logic        day_wrap,
  output logic        load_err
);

  localparam hms_t       RST_T   = hms_t'(RESET_TIME);
  localparam bcd_digit_t HOUR_H1 = 4'(HOUR_MAX / 10);
  localparam bcd_digit_t HOUR_H0 = 4'(HOUR_MAX % 10);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [SYNC_STAGES-1:0] vld_q, vld_d;
  logic                   prev_q, prev_d;
  logic                   armed_q, armed_d;
  logic                   sec_pulse_q, sec_pulse_d;
  logic                   day_wrap_q, day_wrap_d;
  logic                   load_err_q, load_err_d;
  bcd_digit_t             h1_q, h1_d, h0_q, h0_d;

  logic       sync_out, sync_vld, tick, apply_tick, load_ok, hour_inc;
  logic       s0_c, s1_c, m0_c;
  bcd_digit_t s0, s1, m0, m1;
  hms_t       ld_t;

  assign ld_t = hms_t'(load_time);

  // vld tracks how far real samples have propagated through the synchroniser
  // after reset, so the reset-zero fill is never mistaken for clk_1Hz low.
  // Without it a clk_1Hz held high through reset release would arm and tick.
  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], clk_1Hz};
    vld_d       = {vld_q[SYNC_STAGES-2:0], 1'b1};
    sync_out    = sync_q[SYNC_STAGES-1];
    sync_vld    = vld_q[SYNC_STAGES-1];
    prev_d      = sync_out;
    armed_d     = armed_q | (sync_vld & ~sync_out);
    tick        = sync_out & ~prev_q & armed_q;
    load_ok     = load & hms_valid(ld_t);
    // Any load (accepted or not) swallows a coincident tick.
    apply_tick  = tick & run & ~load;
    sec_pulse_d = apply_tick;
    load_err_d  = load & ~load_ok;
  end

  bcd_digit_counter #(.MAX(DIGIT_MAX), .RST_VAL(RST_T.s0)) u_s0 (
    .clk(clk_50MHz), .rst_n(reset_n), .inc(apply_tick), .clr(1'b0),
    .ld(load_ok), .ld_val(ld_t.s0), .q(s0), .carry(s0_c)
  );

  bcd_digit_counter #(.MAX(SEC_TENS_MAX), .RST_VAL(RST_T.s1)) u_s1 (
    .clk(clk_50MHz), .rst_n(reset_n), .inc(s0_c), .clr(1'b0),
    .ld(load_ok), .ld_val(ld_t.s1), .q(s1), .carry(s1_c)
  );

  bcd_digit_counter #(.MAX(DIGIT_MAX), .RST_VAL(RST_T.m0)) u_m0 (
    .clk(clk_50MHz), .rst_n(reset_n), .inc(s1_c), .clr(1'b0),
    .ld(load_ok), .ld_val(ld_t.m0), .q(m0), .carry(m0_c)
  );

  bcd_digit_counter #(.MAX(MIN_TENS_MAX), .RST_VAL(RST_T.m1)) u_m1 (
    .clk(clk_50MHz), .rst_n(reset_n), .inc(m0_c), .clr(1'b0),
    .ld(load_ok), .ld_val(ld_t.m1), .q(m1), .carry(hour_inc)
  );

  // Hours wrap at 23 rather than 99, so the pair is counted as one unit.
  // Any tens digit beyond 2 is out of range and also collapses to 00.
  always_comb begin
    h1_d = h1_q;
    h0_d = h0_q;
    if (load_ok) begin
      h1_d = ld_t.h1;
      h0_d = ld_t.h0;
    end else if (hour_inc) begin
      if ((h1_q > HOUR_H1) || ((h1_q == HOUR_H1) && (h0_q >= HOUR_H0))) begin
        h1_d = '0;
        h0_d = '0;
      end else if (h0_q >= DIGIT_MAX) begin
        h1_d = h1_q + 4'd1;
        h0_d = '0;
      end else begin
        h0_d = h0_q + 4'd1;
      end
    end
    // A carry out of the minutes means every lower digit is already 0.
    day_wrap_d = hour_inc && (h1_d == '0) && (h0_d == '0);
  end

  always_ff @(posedge clk_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      sync_q      <= '0;
      vld_q       <= '0;
      prev_q      <= 1'b0;
      armed_q     <= 1'b0;
      sec_pulse_q <= 1'b0;
      day_wrap_q  <= 1'b0;
      load_err_q  <= 1'b0;
      h1_q        <= RST_T.h1;
      h0_q        <= RST_T.h0;
    end else begin
      sync_q      <= sync_d;
      vld_q       <= vld_d;
      prev_q      <= prev_d;
      armed_q     <= armed_d;
      sec_pulse_q <= sec_pulse_d;
      day_wrap_q  <= day_wrap_d;
      load_err_q  <= load_err_d;
      h1_q        <= h1_d;
      h0_q        <= h0_d;
    end
  end

  assign time_bcd  = {h1_q, h0_q, m1, m0, s1, s0};
  assign sec_pulse = sec_pulse_q;
  assign day_wrap  = day_wrap_q;
  assign load_err  = load_err_q;

endmodule

// File: tb/tb_hms_bcd_counter.sv
// Self-checking bench for hms_bcd_counter. The reference model keeps the
// time as seconds-of-day and applies each sampled clk_1Hz rising edge two
// clock edges after it is first sampled.
module tb_hms_bcd_counter;

  logic        clk_50MHz = 1'b0;
  logic        reset_n   = 1'b1;
  logic        clk_1Hz   = 1'b0;
  logic        run       = 1'b0;
  logic        load      = 1'b0;
  logic [23:0] load_time = '0;
  logic [23:0] time_bcd;
  logic        sec_pulse;
  logic        day_wrap;
  logic        load_err;

  hms_bcd_counter #(.SYNC_STAGES(2), .RESET_TIME(24'h00_00_00)) dut (
    .clk_50MHz(clk_50MHz),
    .reset_n  (reset_n),
    .clk_1Hz  (clk_1Hz),
    .run      (run),
    .load     (load),
    .load_time(load_time),
    .time_bcd (time_bcd),
    .sec_pulse(sec_pulse),
    .day_wrap (day_wrap),
    .load_err (load_err)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  int          checks   = 0;
  int          failures = 0;
  int unsigned secs;
  int          cyc;
  int          due_q[$];
  bit          seen_low, last_s;
  int          sp_cnt, dw_cnt, le_cnt;

  function automatic logic [23:0] to_bcd(input int unsigned s);
    int unsigned h, m, x;
    h = s / 3600;
    m = (s / 60) % 60;
    x = s % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
  endfunction

  function automatic bit decode(input logic [23:0] t, output int unsigned s);
    int unsigned d[6];
    s = 0;
    for (int i = 0; i < 6; i++) d[i] = 32'(t[20-4*i +: 4]);
    for (int i = 0; i < 6; i++) if (d[i] > 9) return 1'b0;
    if (d[2] > 5 || d[4] > 5) return 1'b0;
    if (d[0] * 10 + d[1] > 23) return 1'b0;
    s = (d[0] * 10 + d[1]) * 3600 + (d[2] * 10 + d[3]) * 60 + d[4] * 10 + d[5];
    return 1'b1;
  endfunction

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    secs     = 0;
    cyc      = 0;
    due_q.delete();
    seen_low = 1'b0;
    last_s   = 1'b0;
  endtask

  // One clock: sample driven inputs at the edge, advance the model, then
  // compare all outputs 1 ns later.
  task automatic cycle();
    bit          ck, rn, ld, tick_now, exp_sec, exp_wrap, exp_err;
    logic [23:0] lt;
    int unsigned ns;
    @(posedge clk_50MHz);
    ck = clk_1Hz; rn = run; ld = load; lt = load_time;
    cyc++;
    exp_sec = 1'b0; exp_wrap = 1'b0; exp_err = 1'b0; tick_now = 1'b0;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      tick_now = 1'b1;
      void'(due_q.pop_front());
    end
    if (ld) begin
      if (decode(lt, ns)) secs = ns;
      else exp_err = 1'b1;
    end else if (tick_now && rn) begin
      secs     = (secs + 1) % 86400;
      exp_sec  = 1'b1;
      exp_wrap = (secs == 0);
    end
    if (ck && !last_s && seen_low) due_q.push_back(cyc + 2);
    if (!ck) seen_low = 1'b1;
    last_s = ck;
    #1;
    check("time_bcd", time_bcd, to_bcd(secs));
    check("sec_pulse", 24'(sec_pulse), 24'(exp_sec));
    check("day_wrap", 24'(day_wrap), 24'(exp_wrap));
    check("load_err", 24'(load_err), 24'(exp_err));
    if (sec_pulse) sp_cnt++;
    if (day_wrap) dw_cnt++;
    if (load_err) le_cnt++;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic hz_pulse(input int hi, input int lo);
    clk_1Hz = 1'b1;
    idle(hi);
    clk_1Hz = 1'b0;
    idle(lo);
  endtask

  task automatic do_load(input logic [23:0] t);
    load_time = t;
    load      = 1'b1;
    cycle();
    load      = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_time"}, time_bcd, 24'h000000);
    check({tag, "_sec"}, 24'(sec_pulse), 24'h0);
    check({tag, "_wrap"}, 24'(day_wrap), 24'h0);
    check({tag, "_err"}, 24'(load_err), 24'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [23:0] rt;
    int          r;

    // Reset with clk_1Hz already high.
    clk_1Hz = 1'b1;
    #2 reset_n = 1'b0;
    #3;
    check_reset_state("rst");
    model_reset();
    repeat (3) @(negedge clk_50MHz);
    reset_n = 1'b1;
    run     = 1'b1;
    sp_cnt = 0; dw_cnt = 0; le_cnt = 0;
    idle(6);
    check("no_tick_high_at_release", 24'(sp_cnt), 24'd0);
    clk_1Hz = 1'b0;
    idle(4);
    clk_1Hz = 1'b1;
    cycle();
    check("lat_edge_k", time_bcd, 24'h000000);
    cycle();
    check("lat_edge_k1", time_bcd, 24'h000000);
    cycle();
    check("lat_edge_k2", time_bcd, 24'h000001);
    check("lat_pulse", 24'(sec_pulse), 24'h1);
    idle(3);
    clk_1Hz = 1'b0;
    idle(4);

    // Day wrap.
    do_load(24'h235958);
    sp_cnt = 0; dw_cnt = 0;
    hz_pulse(4, 4);
    check("t235959", time_bcd, 24'h235959);
    hz_pulse(4, 4);
    check("wrap_time", time_bcd, 24'h000000);
    check("wrap_sp_cnt", 24'(sp_cnt), 24'd2);
    check("wrap_dw_cnt", 24'(dw_cnt), 24'd1);

    // Carry chains into the hours.
    dw_cnt = 0;
    do_load(24'h095959);
    hz_pulse(4, 4);
    check("carry_10", time_bcd, 24'h100000);
    do_load(24'h195959);
    hz_pulse(4, 4);
    check("carry_20", time_bcd, 24'h200000);
    check("carry_no_wrap", 24'(dw_cnt), 24'd0);

    // Rejected loads.
    le_cnt = 0;
    do_load(24'h240000);
    check("err_24h", 24'(load_err), 24'h1);
    cycle();
    check("err_one_cycle", 24'(load_err), 24'h0);
    do_load(24'h126000);
    cycle();
    do_load(24'h120A00);
    cycle();
    check("err_hold", time_bcd, 24'h200000);
    do_load(24'h123456);
    check("ok_load", time_bcd, 24'h123456);
    check("ok_no_err", 24'(load_err), 24'h0);
    check("err_count", 24'(le_cnt), 24'd3);

    // Pause.
    run = 1'b0;
    sp_cnt = 0;
    repeat (3) hz_pulse(4, 4);
    check("pause_hold", time_bcd, 24'h123456);
    check("pause_no_pulse", 24'(sp_cnt), 24'd0);
    run = 1'b1;
    hz_pulse(4, 4);
    check("resume", time_bcd, 24'h123457);

    // Load coinciding with the tick cycle.
    clk_1Hz = 1'b1;
    cycle();
    cycle();
    load_time = 24'h010203;
    load      = 1'b1;
    cycle();
    load      = 1'b0;
    check("ld_tick_time", time_bcd, 24'h010203);
    check("ld_tick_nopulse", 24'(sec_pulse), 24'h0);
    idle(3);
    clk_1Hz = 1'b0;
    idle(4);
    hz_pulse(4, 4);
    check("after_ld_tick", time_bcd, 24'h010204);

    // Randomised traffic against the model.
    for (int it = 0; it < 80; it++) begin
      r   = int'($urandom_range(0, 4));
      run = ($urandom_range(0, 3) != 0);
      case (r)
        0: do_load({4'($urandom_range(0, 2)), 4'($urandom_range(0, 9)),
                    4'($urandom_range(0, 6)), 4'($urandom_range(0, 9)),
                    4'($urandom_range(0, 6)), 4'($urandom_range(0, 9))});
        1: do_load(24'($urandom));
        2: do_load({20'h23595, 4'($urandom_range(0, 9))});
        3: begin
          clk_1Hz = 1'b1;
          idle(int'($urandom_range(0, 3)));
          rt = {20'h23595, 4'($urandom_range(0, 9))};
          do_load(rt);
        end
        default: ;
      endcase
      hz_pulse(int'($urandom_range(2, 6)), int'($urandom_range(2, 6)));
    end

    // Reset mid-run with a rising edge in flight; clk_1Hz stays high.
    run = 1'b1;
    do_load(24'h111111);
    clk_1Hz = 1'b1;
    cycle();
    @(negedge clk_50MHz);
    reset_n = 1'b0;
    #1;
    check_reset_state("rst2");
    model_reset();
    repeat (2) @(negedge clk_50MHz);
    reset_n = 1'b1;
    sp_cnt = 0;
    idle(6);
    check("rst2_no_tick", 24'(sp_cnt), 24'd0);
    clk_1Hz = 1'b0;
    idle(4);
    hz_pulse(4, 4);
    check("rst2_first_tick", time_bcd, 24'h000001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
